// File: rtl/add_resp_pkg.sv
// Shared types and the reference sum used by the responder and its scoreboard.
package add_resp_pkg;

   localparam int ADD_W     = 4;
   localparam int ADD_DEPTH = 4;

   typedef logic [ADD_W-1:0] operand_t;
   typedef logic [ADD_W:0]   sum_t;

   // Zero-extend before adding so the carry lands in the extra sum bit.
   function automatic sum_t add_ref(input operand_t a, input operand_t b);
      return sum_t'(a) + sum_t'(b);
   endfunction

endpackage

// File: rtl/add_resp_fifo.sv
// In-order result buffer with an explicit occupancy count and a registered head.
module sync_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             do_push, do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = dout_q;
   assign level   = level_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      // The head is precomputed so dout never shows a stale slot; when the
      // entry being written becomes the new head, take it straight from din.
      if (level_d == '0) begin
         dout_d = '0;
      end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
         dout_d = din;
      end else begin
         dout_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/add_resp.sv
// Operand/sum responder: adds accepted pairs, buffers sums in order and
// keeps wrapping accept/retire counters.
module add_resp
   import add_resp_pkg::*;
#(
   parameter int WIDTH = ADD_W,
   parameter int DEPTH = ADD_DEPTH,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH:0]           y,
   output logic [CNT_W-1:0]         acc_cnt,
   output logic [CNT_W-1:0]         ret_cnt,
   output logic [$clog2(DEPTH):0]   level
);

   logic [WIDTH:0]   sum;
   logic             full, empty, push, pop;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, ret_cnt_q, ret_cnt_d;

   generate
      if (WIDTH == ADD_W) begin : g_ref_add
         assign sum = add_ref(a, b);
      end else begin : g_gen_add
         assign sum = (WIDTH+1)'(a) + (WIDTH+1)'(b);
      end
   endgenerate

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   sync_fifo #(
      .WIDTH (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (sum),
      .dout  (y),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_comb begin
      acc_cnt_d = acc_cnt_q;
      ret_cnt_d = ret_cnt_q;
      if (push) acc_cnt_d = acc_cnt_q + CNT_W'(1);
      if (pop)  ret_cnt_d = ret_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt_q <= '0;
         ret_cnt_q <= '0;
      end else begin
         acc_cnt_q <= acc_cnt_d;
         ret_cnt_q <= ret_cnt_d;
      end
   end

   assign acc_cnt = acc_cnt_q;
   assign ret_cnt = ret_cnt_q;

endmodule

// File: doc/add_resp.md
Name: add_resp

Overview:
- Responder end of the operand/sum exchange used by the adder benches: accepts operand pairs (a, b) from a stimulus driver over a valid/ready handshake.
- Computes the WIDTH+1-bit sum and buffers results in a small in-order FIFO.
- Returns each result to a consumer over a second valid/ready handshake.
- Keeps wrap-around counters of accepted and retired transactions for scoreboarding.

Parameters:
- WIDTH, 4, operand width; the sum is WIDTH+1 bits.
- DEPTH, 4, result FIFO entries; must be a power of two, at least 2.
- CNT_W, 8, width of the transaction counters.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  driver presents an operand pair.
- in_ready  out  1  responder can accept; equals !full.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  head result available; equals !empty.
- out_ready  in  1  consumer takes head result.
- y  out  WIDTH+1  head result (a+b).
- acc_cnt  out  CNT_W  number of accepted pairs, wrapping.
- ret_cnt  out  CNT_W  number of retired results, wrapping.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: synchronous, active-high. When rst=1 at a posedge, the next state is:
  - rd_ptr=wr_ptr=0, level=0, acc_cnt=0, ret_cnt=0.
  - out_valid=0, y=0, in_ready=1.
  - FIFO contents are don't-care.
- Reset mid-operation discards all buffered results. No handshake completes in a reset cycle, even if valid and ready are both high.
- Push: when in_valid && in_ready, the value a+b is written at wr_ptr.
  - The sum is zero-extended to WIDTH+1 bits, so there is no overflow loss. Example: 15+15 gives 30.
  - wr_ptr increments modulo DEPTH.
  - acc_cnt increments and wraps to 0 after 2^CNT_W-1.
- Pop: when out_valid && out_ready, rd_ptr increments modulo DEPTH and ret_cnt increments, wrapping the same way.
- Latency: a pair accepted at edge N is visible on y with out_valid=1 after edge N (one-cycle latency), provided the FIFO was empty. Results always leave in acceptance order.
- y always shows the entry at rd_ptr when out_valid=1, and is 0 when empty. y must not glitch to a stale entry.
- Full condition: level==DEPTH, so in_ready=0.
  - A pop in the same cycle does NOT enable a push; there is no bypass and in_ready has no combinational dependence on out_ready.
  - in_ready returns to 1 the cycle after the pop.
- Empty condition: level==0, so out_valid=0.
  - A push in the same cycle is not presented that cycle; there is no fall-through.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both pointers advance.
- in_valid while in_ready=0: the pair is not consumed. The driver must hold a and b stable until acceptance; the responder does not check this.
- out_ready while out_valid=0: ignored, and counters do not change.
- Invariant: level == acc_cnt - ret_cnt (mod 2^CNT_W), provided DEPTH < 2^CNT_W.
- Pointers are $clog2(DEPTH) bits wide. level is maintained explicitly so full and empty are unambiguous.

Decomposition:
- Package add_resp_pkg holds:
  - default constants ADD_W=4 and ADD_DEPTH=4;
  - typedef operand_t logic[ADD_W-1:0];
  - typedef sum_t logic[ADD_W:0];
  - function add_ref(a,b) returning sum_t, shared by the RTL and the bench scoreboard.
- One sub-module, sync_fifo (WIDTH, DEPTH, synchronous active-high reset, registered output, no bypass), instantiated with WIDTH+1 data.
- add_resp holds the adder, the handshake glue and the counters.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release, wait 3 cycles → in_ready=1, out_valid=0, y=0, level=0, acc_cnt=ret_cnt=0.
- Directed sums with out_ready=1: push (1,3), (5,6), (7,8), (15,15) on consecutive cycles → y sequence 4, 11, 15, 30, each one cycle after acceptance; final acc_cnt=ret_cnt=4.
- Fill and backpressure: out_ready=0, push 5 pairs (i,i) for i=1..5 → in_ready drops after 4, level=4, pair 5 held off. Then out_ready=1 for one cycle with in_valid=1 → pair 5 is not accepted that cycle but is accepted the next; drained order is 2, 4, 6, 8, 10.
- Simultaneous push/pop at level=2: in_valid=out_ready=1 for 3 cycles → level stays 2, results stay in order.
- Reset mid-operation: level=3, assert rst for 1 cycle with in_valid=out_ready=1 → level=0, out_valid=0, counters 0, no handshake counted.
- Counter wrap: 260 randomized accepted and retired transactions with CNT_W=8 → acc_cnt=ret_cnt=4; every y equals add_ref(a,b).
